// File: rtl/cpu_defs.sv
// Shared CPU constants: boot/exception vectors, the NOP encoding, the IF/ID FSM
// state encoding and the fetch-record type used by the IF/ID hold buffer.
package cpu_defs;

    localparam logic [31:0] RESET_ADDR  = 32'hbfc00000;
    localparam logic [31:0] EXCEPT_ADDR = 32'hbfc00380;
    localparam logic [31:0] NOP_INST    = 32'h00000000;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_t;

    // A faulting fetch carries its address but never its (meaningless) data.
    function automatic fetch_t make_fetch(input logic [31:0] pc,
                                          input logic [31:0] rdata,
                                          input logic        adel,
                                          input logic [31:0] nop);
        fetch_t f;
        f.pc   = pc;
        f.inst = adel ? nop : rdata;
        f.adel = adel;
        return f;
    endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// Fetch/stall event counters for the IF/ID stage; only built when
// IF_PERF_CNT_EN is defined. Both wrap at 2^32 and clear only on rst.
module if_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (fetch_inc) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_inc) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: pairs synchronous I-SRAM data with its PC, handles
// stall hold buffering, flush/boot bubbles. Optional counters: IF_PERF_CNT_EN.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_ADDR,
    parameter logic [31:0] NOP_INST = cpu_defs::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IRWrite,
    input  logic        flush,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_adel,
    input  logic [31:0] inst_sram_rdata,
    input  logic        id_is_branch,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_Inst,
    output logic [31:0] IF_ID_PCplus4,
    output logic        IF_ID_AdEL,
    output logic        IF_ID_BD,
    output logic        IF_ID_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    logic [1:0]       state;
    cpu_defs::fetch_t hold_q;
    cpu_defs::fetch_t live;
    cpu_defs::fetch_t src;
    logic             bubble;
    logic             advance;
    logic             capture;

    // After a stall the SRAM has moved on; the held word is the one to use.
    always_comb begin
        live    = cpu_defs::make_fetch(fetch_pc, inst_sram_rdata, fetch_adel, NOP_INST);
        src     = (state == cpu_defs::ST_HOLD) ? hold_q : live;
        bubble  = rst || flush || (state == cpu_defs::ST_BOOT);
        advance = !bubble && IRWrite;
        capture = !rst && !flush && !IRWrite && (state == cpu_defs::ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= cpu_defs::ST_BOOT;
        end else if (flush) begin
            state <= cpu_defs::ST_RUN;
        end else begin
            case (state)
                cpu_defs::ST_BOOT: if (IRWrite)  state <= cpu_defs::ST_RUN;
                cpu_defs::ST_RUN:  if (!IRWrite) state <= cpu_defs::ST_HOLD;
                cpu_defs::ST_HOLD: if (IRWrite)  state <= cpu_defs::ST_RUN;
                default:                         state <= cpu_defs::ST_BOOT;
            endcase
        end
    end

    // Reset, flush and the boot cycle all produce the same bubble.
    always_ff @(posedge clk) begin
        if (bubble) begin
            IF_ID_PC      <= RESET_PC;
            IF_ID_Inst    <= NOP_INST;
            IF_ID_PCplus4 <= RESET_PC + 32'd4;
            IF_ID_AdEL    <= 1'b0;
            IF_ID_BD      <= 1'b0;
            IF_ID_valid   <= 1'b0;
        end else if (advance) begin
            IF_ID_PC      <= src.pc;
            IF_ID_Inst    <= src.inst;
            IF_ID_PCplus4 <= src.pc + 32'd4;
            IF_ID_AdEL    <= src.adel;
            IF_ID_BD      <= id_is_branch && IF_ID_valid;
            IF_ID_valid   <= 1'b1;
        end
    end

    // NOTE: the hold buffer has no reset; it is only read in HOLD, which is
    // reachable solely through a fresh capture.
    always_ff @(posedge clk) begin
        if (capture) hold_q <= live;
    end

`ifdef IF_PERF_CNT_EN
    if_perf_cnt u_perf (
        .clk            (clk),
        .rst            (rst),
        .fetch_inc      (advance),
        .stall_inc      (!IRWrite),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule
